// File: rtl/spmv_vec_prefetch.sv
// Dense-vector prefetch for SpMV: fetches x in 64 B lines while prefetch is high,
// then serves one registered col_idx -> x[col_idx] lookup per cycle while done.
module spmv_vec_prefetch #(
    parameter int VEC_W     = 32,
    parameter int LINE_W    = 512,
    parameter int MAX_LINES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spmv_init,
    input  logic              prefetch,
    input  logic [39:0]       vec_pntr,
    input  logic [15:0]       vec_len,
    input  logic              mem_req_rdy,
    output logic              mem_req_val,
    output logic [5:0]        mem_req_transid,
    output logic [39:0]       mem_req_addr,
    input  logic              mem_resp_val,
    input  logic [5:0]        mem_resp_transid,
    input  logic [LINE_W-1:0] mem_resp_data,
    input  logic              col_idx_val,
    input  logic [15:0]       col_idx_in,
    output logic              col_val_val,
    output logic [VEC_W-1:0]  col_val_out,
    output logic              prefetch_done,
    output logic              vec_err
);
    localparam int LINE_AW = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int CNT_W   = 7;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e               state_q, state_d;
    logic [3:0]           off_q, off_d;
    logic [33:0]          base_line_q, base_line_d;
    logic [CNT_W-1:0]     num_lines_q, num_lines_d;
    logic [15:0]          vec_len_q, vec_len_d;
    logic [CNT_W-1:0]     req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]     resp_cnt_q, resp_cnt_d;
    logic [CNT_W-1:0]     outstanding_q, outstanding_d;
    logic [MAX_LINES-1:0] line_vld_q, line_vld_d;
    logic                 vec_err_q, vec_err_d;
    logic                 col_val_val_q, col_val_val_d;
    logic [VEC_W-1:0]     col_val_out_q, col_val_out_d;

    logic [LINE_W-1:0]    line_mem [MAX_LINES];

    logic [16:0]          num_lines_calc;
    logic                 req_hs, resp_dec, resp_wr;
    logic [LINE_AW-1:0]   resp_tid;
    logic [16:0]          lk_elem;
    logic [LINE_AW-1:0]   lk_line;
    logic [3:0]           lk_word;
    logic                 lk_hit;
    logic [LINE_W-1:0]    lk_data;
    logic                 unused_bits;

    assign num_lines_calc = ({13'd0, vec_pntr[5:2]} + {1'b0, vec_len} + 17'd15) >> 4;
    assign req_hs   = (state_q == ISSUE) && mem_req_rdy;
    assign resp_dec = mem_resp_val && (outstanding_q != '0);
    assign resp_tid = mem_resp_transid[LINE_AW-1:0];
    // Only an in-range, not-yet-seen line is written, and only while a fetch is live.
    assign resp_wr  = mem_resp_val && !spmv_init
                   && ((state_q == ISSUE) || (state_q == WAIT))
                   && ({1'b0, mem_resp_transid} < num_lines_q)
                   && !line_vld_q[resp_tid];

    assign lk_elem = {13'd0, off_q} + {1'b0, col_idx_in};
    assign lk_line = lk_elem[LINE_AW+3:4];
    assign lk_word = lk_elem[3:0];
    assign lk_hit  = (col_idx_in < vec_len_q) && !vec_err_q;
    assign lk_data = line_mem[lk_line];
    assign unused_bits = ^{vec_pntr[1:0], lk_elem[16:LINE_AW+4]};

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d       = state_q;
        off_d         = off_q;
        base_line_d   = base_line_q;
        num_lines_d   = num_lines_q;
        vec_len_d     = vec_len_q;
        req_cnt_d     = req_cnt_q + CNT_W'(req_hs);
        resp_cnt_d    = resp_cnt_q + CNT_W'(resp_wr);
        outstanding_d = outstanding_q + CNT_W'(req_hs) - CNT_W'(resp_dec);
        line_vld_d    = line_vld_q;
        vec_err_d     = vec_err_q;
        if (resp_wr) line_vld_d[resp_tid] = 1'b1;

        case (state_q)
            IDLE: begin
                off_d       = vec_pntr[5:2];
                base_line_d = vec_pntr[39:6];
                num_lines_d = num_lines_calc[CNT_W-1:0];
                vec_len_d   = vec_len;
                if (prefetch && (outstanding_q == '0)) begin
                    if (vec_len == 16'd0) begin
                        state_d = DONE;
                    end else if (num_lines_calc > 17'(MAX_LINES)) begin
                        state_d   = DONE;
                        vec_err_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: if (req_hs && (req_cnt_q == num_lines_q - CNT_W'(1))) state_d = WAIT;
            WAIT:  if (resp_cnt_d == num_lines_q) state_d = DONE;
            default: ;
        endcase

        // Outstanding survives init so late responses from an aborted fetch drain first.
        if (spmv_init) begin
            state_d    = IDLE;
            req_cnt_d  = '0;
            resp_cnt_d = '0;
            line_vld_d = '0;
            vec_err_d  = 1'b0;
        end
    end

    always_comb begin
        col_val_val_d = col_idx_val && (state_q == DONE);
        col_val_out_d = col_val_out_q;
        if (col_val_val_d) col_val_out_d = lk_hit ? lk_data[lk_word*VEC_W +: VEC_W] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            off_q         <= '0;
            base_line_q   <= '0;
            num_lines_q   <= '0;
            vec_len_q     <= '0;
            req_cnt_q     <= '0;
            resp_cnt_q    <= '0;
            outstanding_q <= '0;
            line_vld_q    <= '0;
            vec_err_q     <= 1'b0;
            col_val_val_q <= 1'b0;
            col_val_out_q <= '0;
        end else begin
            state_q       <= state_d;
            off_q         <= off_d;
            base_line_q   <= base_line_d;
            num_lines_q   <= num_lines_d;
            vec_len_q     <= vec_len_d;
            req_cnt_q     <= req_cnt_d;
            resp_cnt_q    <= resp_cnt_d;
            outstanding_q <= outstanding_d;
            line_vld_q    <= line_vld_d;
            vec_err_q     <= vec_err_d;
            col_val_val_q <= col_val_val_d;
            col_val_out_q <= col_val_out_d;
        end
    end

    // NOTE: line storage has no reset; the valid bits alone decide what is trusted.
    always_ff @(posedge clk) begin
        if (resp_wr) line_mem[resp_tid] <= mem_resp_data;
    end

    assign mem_req_val     = (state_q == ISSUE);
    assign mem_req_addr    = mem_req_val ? {base_line_q + {27'd0, req_cnt_q}, 6'd0} : '0;
    assign mem_req_transid = mem_req_val ? req_cnt_q[5:0] : '0;
    assign prefetch_done   = (state_q == DONE);
    assign vec_err         = vec_err_q;
    assign col_val_val     = col_val_val_q;
    assign col_val_out     = col_val_out_q;
endmodule
